// File: rtl/br128_ctrl_if.sv
// Request/response and macro-pin bundle between the bus front end, br128_ctrl and the BR128 macro.
// master = front end plus macro side, slave = controller; the signal names match the macro/bus pin names.
interface br128_ctrl_if;
    logic         REQ;
    logic [127:0] CHAL;
    logic [7:0]   SETTLE;
    logic         BUSY;
    logic         RESP_VALID;
    logic         RESP;
    logic         STABLE;
    logic         PUF_RESET;
    logic [127:0] PUF_C;
    logic         PUF_OUT;

    modport master (
        output REQ, CHAL, SETTLE, PUF_OUT,
        input  BUSY, RESP_VALID, RESP, STABLE, PUF_RESET, PUF_C
    );

    modport slave (
        input  REQ, CHAL, SETTLE, PUF_OUT,
        output BUSY, RESP_VALID, RESP, STABLE, PUF_RESET, PUF_C
    );
endinterface

// File: rtl/br128_ctrl.sv
// BR128 PUF sequencer: NVOTE x (reset RST_CYC, release SETTLE+2, sample), then a majority-voted response.
// Latency NVOTE*(RST_CYC+SETTLE+2)+1 cycles; there is no backpressure, and REQ is ignored (not queued) while BUSY.
module br128_ctrl #(
    parameter int NVOTE   = 5,
    parameter int RST_CYC = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    br128_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RST, WAIT, DONE} state_t;

    localparam logic [3:0] NVOTE_L  = 4'(NVOTE);
    localparam logic [3:0] HALF_L   = 4'(NVOTE / 2);
    localparam logic [8:0] RST_LOAD = 9'(RST_CYC - 1);

    state_t       state_q, state_d;
    logic [8:0]   cnt_q, cnt_d;
    logic [3:0]   eval_q, eval_d;
    logic [3:0]   ones_q, ones_d;
    logic [7:0]   settle_q, settle_d;
    logic [127:0] chal_q, chal_d;
    logic         sync1_q, sync2_q;
    logic         busy_q, busy_d;
    logic         resp_valid_q, resp_valid_d;
    logic         resp_q, resp_d;
    logic         stable_q, stable_d;
    logic         puf_reset_q, puf_reset_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eval_d   = eval_q;
        ones_d   = ones_q;
        settle_d = settle_q;
        chal_d   = chal_q;
        resp_d   = resp_q;
        stable_d = stable_q;

        case (state_q)
            IDLE: begin
                if (bus.REQ) begin
                    chal_d   = bus.CHAL;
                    settle_d = bus.SETTLE;
                    ones_d   = 4'd0;
                    eval_d   = 4'd0;
                    cnt_d    = RST_LOAD;
                    state_d  = RST;
                end
            end
            RST: begin
                if (cnt_q == 9'd0) begin
                    // SETTLE+1 down to 0 gives SETTLE+2 released cycles
                    cnt_d   = {1'b0, settle_q} + 9'd1;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            WAIT: begin
                if (cnt_q == 9'd0) begin
                    ones_d = ones_q + {3'b000, sync2_q};
                    eval_d = eval_q + 4'd1;
                    if (eval_d < NVOTE_L) begin
                        cnt_d   = RST_LOAD;
                        state_d = RST;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so the macro pins never glitch.
        busy_d       = (state_d != IDLE);
        resp_valid_d = (state_d == DONE);
        puf_reset_d  = (state_d != WAIT);
        if (state_d == DONE) begin
            resp_d   = (ones_d > HALF_L);
            stable_d = (ones_d == 4'd0) || (ones_d == NVOTE_L);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            cnt_q        <= 9'd0;
            eval_q       <= 4'd0;
            ones_q       <= 4'd0;
            settle_q     <= 8'd0;
            chal_q       <= 128'd0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_q       <= 1'b0;
            stable_q     <= 1'b0;
            puf_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            eval_q       <= eval_d;
            ones_q       <= ones_d;
            settle_q     <= settle_d;
            chal_q       <= chal_d;
            sync1_q      <= bus.PUF_OUT;
            sync2_q      <= sync1_q;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            stable_q     <= stable_d;
            puf_reset_q  <= puf_reset_d;
        end
    end

    assign bus.BUSY       = busy_q;
    assign bus.RESP_VALID = resp_valid_q;
    assign bus.RESP       = resp_q;
    assign bus.STABLE     = stable_q;
    assign bus.PUF_RESET  = puf_reset_q;
    assign bus.PUF_C      = chal_q;

endmodule

// File: tb/tb_br128_ctrl.sv
// Randomized bench for br128_ctrl: a timing/vote model feeds a scoreboard that a negedge monitor drains.
// The PUF_OUT driver plays a per-evaluation bit pattern chosen by the stimulus.
module tb_br128_ctrl;
    localparam int NV = 5;
    localparam int RC = 4;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    br128_ctrl_if bus();

    br128_ctrl #(.NVOTE(NV), .RST_CYC(RC)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int   cyc;
        logic resp;
        logic stable;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    exp_t         rq[$];
    int           wq[$];
    bit           have_req = 1'b0;
    int           cur_e0 = 0;
    int           cur_end = 0;
    int           cur_p = 1;
    logic [15:0]  cur_pat = 16'd0;
    logic [127:0] cur_chal = 128'd0;
    logic [127:0] prev_chal = 128'd0;
    int           run = 0;
    bit           mon_busy;
    exp_t         mon_e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // cyc = index of the most recent rising edge; cycle "cyc" is the period after it.
    always @(posedge CLK) cyc = cyc + 1;

    // Evaluation k of the current request owns cycles [e0+k*P, e0+(k+1)*P).
    always @(posedge CLK) begin
        #1;
        if (have_req && cyc >= cur_e0 && cyc < cur_end)
            bus.PUF_OUT = cur_pat[(cyc - cur_e0) / cur_p];
        else
            bus.PUF_OUT = 1'($urandom);
    end

    always @(negedge CLK) begin
        if (!RESET_N) begin
            run = 0;
        end else begin
            mon_busy = have_req && cyc >= cur_e0 && cyc <= cur_end;
            chk("busy", 128'(bus.BUSY), 128'(mon_busy));
            chk("puf_c", bus.PUF_C, (have_req && cyc >= cur_e0) ? cur_chal : prev_chal);
            if (!mon_busy) chk("puf_reset_idle", 128'(bus.PUF_RESET), 128'd1);
            if (have_req && cyc == cur_end) chk("resp_valid_due", 128'(bus.RESP_VALID), 128'd1);
            if (bus.RESP_VALID) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_valid_unexpected: pulse at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = rq.pop_front();
                    chk("resp_cycle", 128'(cyc), 128'(mon_e.cyc));
                    chk("resp", 128'(bus.RESP), 128'(mon_e.resp));
                    chk("stable", 128'(bus.STABLE), 128'(mon_e.stable));
                end
            end
            if (!bus.PUF_RESET) begin
                run++;
            end else if (run > 0) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL low_window_unexpected: width %0d, expected no window", run);
                end else begin
                    chk("low_width", 128'(run), 128'(wq.pop_front()));
                end
                run = 0;
            end
        end
    end

    // All stimulus tasks run in the posedge+1 phase.
    task automatic wait_idle();
        while (have_req && cyc <= cur_end) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic issue(input logic [127:0] c, input logic [7:0] s, input logic [15:0] p, input bit hold);
        int   ones;
        exp_t e;
        wait_idle();
        bus.CHAL   = c;
        bus.SETTLE = s;
        bus.REQ    = 1'b1;
        prev_chal  = cur_chal;
        cur_chal   = c;
        cur_e0     = cyc + 1;
        cur_p      = RC + int'(s) + 2;
        cur_pat    = p;
        cur_end    = cur_e0 + NV * cur_p;
        have_req   = 1'b1;
        ones = 0;
        for (int k = 0; k < NV; k++) ones += int'(p[k]);
        e.cyc    = cur_end;
        e.resp   = (2 * ones > NV);
        e.stable = (ones == 0) || (ones == NV);
        rq.push_back(e);
        for (int k = 0; k < NV; k++) wq.push_back(int'(s) + 2);
        @(posedge CLK); #1;
        if (!hold) bus.REQ = 1'b0;
        bus.CHAL   = {$urandom, $urandom, $urandom, $urandom};
        bus.SETTLE = 8'($urandom);
    endtask

    task automatic reset_mid();
        issue({$urandom, $urandom, $urandom, $urandom}, 8'd10, 16'($urandom), 1'b0);
        while (cyc < cur_e0 + RC + 3) begin
            @(posedge CLK); #1;
        end
        #1 RESET_N = 1'b0;
        #1;
        chk("arst_puf_reset", 128'(bus.PUF_RESET), 128'd1);
        chk("arst_busy", 128'(bus.BUSY), 128'd0);
        chk("arst_resp_valid", 128'(bus.RESP_VALID), 128'd0);
        chk("arst_puf_c", bus.PUF_C, 128'd0);
        chk("arst_resp", 128'(bus.RESP), 128'd0);
        chk("arst_stable", 128'(bus.STABLE), 128'd0);
        have_req  = 1'b0;
        cur_chal  = 128'd0;
        prev_chal = 128'd0;
        rq.delete();
        wq.delete();
        repeat (3) @(posedge CLK);
        #2 RESET_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        bus.REQ    = 1'b0;
        bus.CHAL   = 128'd0;
        bus.SETTLE = 8'd0;
        RESET_N    = 1'b0;
        #12;
        chk("rst_puf_reset", 128'(bus.PUF_RESET), 128'd1);
        chk("rst_puf_c", bus.PUF_C, 128'd0);
        chk("rst_busy", 128'(bus.BUSY), 128'd0);
        chk("rst_resp_valid", 128'(bus.RESP_VALID), 128'd0);
        chk("rst_resp", 128'(bus.RESP), 128'd0);
        chk("rst_stable", 128'(bus.STABLE), 128'd0);
        @(posedge CLK);
        #2 RESET_N = 1'b1;
        repeat (20) @(posedge CLK);
        #1;

        // Directed vote patterns: all ones, 1,0,1,0,1 and 0,1,0,1,0 (bit k = evaluation k).
        issue({16{8'hA5}}, 8'd3, 16'h001F, 1'b0);
        issue({$urandom, $urandom, $urandom, $urandom}, 8'd3, 16'h0015, 1'b0);
        issue({$urandom, $urandom, $urandom, $urandom}, 8'd3, 16'h000A, 1'b0);

        // Settle extremes, with REQ pulses during the long run that must be ignored.
        issue({$urandom, $urandom, $urandom, $urandom}, 8'd0, 16'($urandom), 1'b0);
        issue({$urandom, $urandom, $urandom, $urandom}, 8'd255, 16'($urandom), 1'b0);
        repeat (50) @(posedge CLK);
        #1;
        bus.REQ  = 1'b1;
        bus.CHAL = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge CLK);
        #1 bus.REQ = 1'b0;

        // Back-to-back with REQ held high.
        for (int i = 0; i < 4; i++)
            issue({$urandom, $urandom, $urandom, $urandom}, 8'($urandom_range(0, 6)), 16'($urandom), 1'b1);
        while (cyc < cur_end) begin
            @(posedge CLK); #1;
        end
        bus.REQ = 1'b0;

        // Random requests with random idle gaps.
        for (int i = 0; i < 15; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK); #1;
            end
            issue({$urandom, $urandom, $urandom, $urandom}, 8'($urandom_range(0, 12)), 16'($urandom), 1'b0);
        end

        reset_mid();
        issue({$urandom, $urandom, $urandom, $urandom}, 8'd5, 16'($urandom), 1'b0);

        wait_idle();
        repeat (3) @(posedge CLK);
        #1;
        chk("resp_queue_empty", 128'(rq.size()), 128'd0);
        chk("width_queue_empty", 128'(wq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
